// File: rtl/rv32im_bus_pkg.sv
// Shared types and constants for the rv32im two-master Wishbone arbiter.
package rv32im_bus_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned MASTER_PREFETCH = 0;
  localparam int unsigned MASTER_LSU      = 1;
  localparam int unsigned NUM_MASTERS     = 2;
  localparam int unsigned SEL_W           = 4;

endpackage

// File: rtl/rv32im_arb_timeout.sv
// Slave wait watchdog: counts stalled strobe cycles and flags the cycle that reaches LIMIT.
module rv32im_arb_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The LIMIT-th consecutive stalled cycle is the one that fires.
  assign hit_o = inc_i & (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i | hit_o) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// Two-master Wishbone arbiter (prefetch = master 0, load/store = master 1) onto one slave port.
// Optional slave-stall watchdog enabled by defining RV32IM_ARB_TIMEOUT_EN.
module rv32im_bus_arbiter
  import rv32im_bus_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [NUM_MASTERS-1:0]        req_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  input  logic [2*(XLEN-2)-1:0]         m_adr_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*SEL_W-1:0]  m_sel_i,
  input  logic [2*XLEN-1:0]             m_dat_i,
  output logic [XLEN-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [XLEN-3:0]               s_adr_o,
  output logic [XLEN-1:0]               s_dat_o,
  output logic                          s_we_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic [SEL_W-1:0]              s_sel_o,
  input  logic [XLEN-1:0]               s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i
);

  localparam int unsigned AW = XLEN - 2;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  arb_state_e state_q;
  logic       last_q;
  logic       own_req_c;
  logic       release_c;
  logic       tmo_hit_c;
  logic       ack_c;
  logic       err_c;

  // Owner register; last_q remembers who was served most recently for tie-breaks.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'(MASTER_LSU);
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (&req_i) begin
            state_q <= (last_q == 1'(MASTER_LSU)) ? ARB_OWN0 : ARB_OWN1;
          end else if (req_i[MASTER_PREFETCH]) begin
            state_q <= ARB_OWN0;
          end else if (req_i[MASTER_LSU]) begin
            state_q <= ARB_OWN1;
          end
        end
        ARB_OWN0: begin
          if (tmo_hit_c | release_c) begin
            last_q  <= 1'(MASTER_PREFETCH);
            state_q <= (~tmo_hit_c & req_i[MASTER_LSU]) ? ARB_OWN1 : ARB_IDLE;
          end
        end
        ARB_OWN1: begin
          if (tmo_hit_c | release_c) begin
            last_q  <= 1'(MASTER_LSU);
            state_q <= (~tmo_hit_c & req_i[MASTER_PREFETCH]) ? ARB_OWN0 : ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant_o = {state_q == ARB_OWN1, state_q == ARB_OWN0};
  assign s_cyc_o = (state_q != ARB_IDLE);

  // Slave-side mux from the owner; everything reads zero with no owner.
  always_comb begin
    own_req_c = 1'b0;
    s_stb_o   = 1'b0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    unique case (state_q)
      ARB_OWN0: begin
        own_req_c = req_i[MASTER_PREFETCH];
        s_stb_o   = req_i[MASTER_PREFETCH] & m_stb_i[MASTER_PREFETCH];
        s_adr_o   = m_adr_i[MASTER_PREFETCH*AW +: AW];
        s_dat_o   = m_dat_i[MASTER_PREFETCH*XLEN +: XLEN];
        s_we_o    = m_we_i[MASTER_PREFETCH];
        s_sel_o   = m_sel_i[MASTER_PREFETCH*SEL_W +: SEL_W];
      end
      ARB_OWN1: begin
        own_req_c = req_i[MASTER_LSU];
        s_stb_o   = req_i[MASTER_LSU] & m_stb_i[MASTER_LSU];
        s_adr_o   = m_adr_i[MASTER_LSU*AW +: AW];
        s_dat_o   = m_dat_i[MASTER_LSU*XLEN +: XLEN];
        s_we_o    = m_we_i[MASTER_LSU];
        s_sel_o   = m_sel_i[MASTER_LSU*SEL_W +: SEL_W];
      end
      default: ;
    endcase
  end

  assign release_c = s_cyc_o & ~own_req_c;

`ifdef RV32IM_ARB_TIMEOUT_EN
  rv32im_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (s_stb_o & ~s_ack_i & ~s_err_i),
    .clr_i   (release_c | (s_stb_o & (s_ack_i | s_err_i))),
    .hit_o   (tmo_hit_c)
  );
`else
  assign tmo_hit_c = 1'b0;
`endif

  // Terminations only reach the current owner, and only while it strobes.
  assign ack_c   = s_ack_i & s_stb_o;
  assign err_c   = (s_err_i & s_stb_o) | tmo_hit_c;
  assign m_ack_o = {NUM_MASTERS{ack_c}} & grant_o;
  assign m_err_o = {NUM_MASTERS{err_c}} & grant_o;
  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// Self-checking bench for rv32im_bus_arbiter: per-cycle ownership model plus directed literal checks.
`timescale 1ns/1ps
module tb_rv32im_bus_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 30;
  localparam int unsigned TMO  = 8;

  logic            clk = 1'b0;
  logic            reset_i;
  logic [1:0]      req, stb, we;
  logic [7:0]      sel;
  logic [AW-1:0]   adr0, adr1;
  logic [31:0]     dat0, dat1, s_dat;
  logic            s_ack, s_err;

  logic [1:0]      grant, m_ack, m_err;
  logic [31:0]     m_dat, s_dat_o;
  logic [AW-1:0]   s_adr;
  logic            s_we, s_cyc, s_stb;
  logic [3:0]      s_sel;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  rv32im_bus_arbiter #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .req_i   (req),
    .grant_o (grant),
    .m_adr_i ({adr1, adr0}),
    .m_stb_i (stb),
    .m_we_i  (we),
    .m_sel_i (sel),
    .m_dat_i ({dat1, dat0}),
    .m_dat_o (m_dat),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .s_adr_o (s_adr),
    .s_dat_o (s_dat_o),
    .s_we_o  (s_we),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_sel_o (s_sel),
    .s_dat_i (s_dat),
    .s_ack_i (s_ack),
    .s_err_i (s_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: owner (-1 none, 0 prefetch, 1 lsu), last served master, stalled-cycle count.
  int own   = -1;
  int last  = 1;
  int waitc = 0;

  function automatic bit stb_exp();
    if (own < 0) return 1'b0;
    return req[own[0]] && stb[own[0]];
  endfunction

  function automatic bit tmo_now();
`ifdef RV32IM_ARB_TIMEOUT_EN
    return stb_exp() && !s_ack && !s_err && (waitc == int'(TMO) - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge reset_i) begin
    int nxt;
    bit busy, term, tmo;
    if (reset_i) begin
      own = -1; last = 1; waitc = 0;
    end else begin
      busy = stb_exp();
      term = busy && (s_ack || s_err);
      tmo  = tmo_now();
      nxt  = own;
      if (own < 0) begin
        if (req == 2'b11) nxt = 1 - last;
        else if (req[0])  nxt = 0;
        else if (req[1])  nxt = 1;
      end else if (tmo) begin
        last = own; nxt = -1;
      end else if (!req[own[0]]) begin
        last = own;
        nxt  = req[1 - own] ? 1 - own : -1;
      end
      if (nxt != own || term) waitc = 0;
      else if (busy)          waitc++;
      own = nxt;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] eg;
    bit es;
    if (cmp_en) begin
      eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      es = stb_exp();
      chk("grant", 64'(grant), 64'(eg));
      chk("cyc",   64'(s_cyc), 64'(own >= 0));
      chk("stb",   64'(s_stb), 64'(es));
      chk("adr",   64'(s_adr), (own == 0) ? 64'(adr0) : (own == 1) ? 64'(adr1) : 64'h0);
      chk("wdat",  64'(s_dat_o), (own == 0) ? 64'(dat0) : (own == 1) ? 64'(dat1) : 64'h0);
      chk("we",    64'(s_we), (own >= 0) ? 64'(we[own[0]]) : 64'h0);
      chk("sel",   64'(s_sel), (own == 0) ? 64'(sel[3:0]) : (own == 1) ? 64'(sel[7:4]) : 64'h0);
      chk("ack",   64'(m_ack), (s_ack && es) ? 64'(eg) : 64'h0);
      chk("err",   64'(m_err), ((s_err && es) || tmo_now()) ? 64'(eg) : 64'h0);
      chk("rdat",  64'(m_dat), 64'(s_dat));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    reset_i = 1'b1; req = '0; stb = '0; we = '0; sel = '0;
    adr0 = '0; adr1 = '0; dat0 = '0; dat1 = '0; s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
    step();
    cmp_en = 1'b1;
    step(); #2;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_cyc",   64'(s_cyc), 64'h0);
    chk("rst_adr",   64'(s_adr), 64'h0);
    chk("rst_ack",   64'(m_ack), 64'h0);

    // First tie after reset goes to prefetch; prefetch reads word 0x10 (byte 0x40).
    step();
    reset_i = 1'b0; req = 2'b11; stb = 2'b11; sel = 8'b0000_1111;
    adr0 = 30'h10; adr1 = 30'h200; dat0 = 32'h1111_2222; s_dat = 32'h0010_0093;
    step(); #2;
    chk("tie_grant", 64'(grant), 64'h1);
    chk("tie_adr",   64'(s_adr), 64'h10);
    s_ack = 1'b1; #1;
    chk("pf_ack",  64'(m_ack), 64'h1);
    chk("pf_rdat", 64'(m_dat), 64'h0010_0093);

    // Prefetch drops on ack; LSU waits through the dead cycle with a write queued.
    step();
    req = 2'b10; stb = 2'b10; s_ack = 1'b0;
    we = 2'b10; sel = 8'b0011_1111; dat1 = 32'hDEAD_BEEF; #2;
    chk("dead_grant", 64'(grant), 64'h1);
    chk("dead_stb",   64'(s_stb), 64'h0);
    step(); #2;
    chk("lsu_grant", 64'(grant), 64'h2);
    chk("lsu_sel",   64'(s_sel), 64'h3);
    chk("lsu_we",    64'(s_we), 64'h1);
    chk("lsu_dat",   64'(s_dat_o), 64'hDEAD_BEEF);
    chk("lsu_adr",   64'(s_adr), 64'h200);
    s_ack = 1'b1; req = 2'b11; stb = 2'b11; #1;
    chk("lsu_ack", 64'(m_ack), 64'h2);
    step();
    req = 2'b01; stb = 2'b01; #2;
    chk("lsu_dead_ack", 64'(m_ack), 64'h0);
    step();
    req = 2'b11; stb = 2'b11; #2;
    chk("pf_we", 64'(s_we), 64'h0);
    chk("pf_sel", 64'(s_sel), 64'hF);
    chk("pf_wdat", 64'(s_dat_o), 64'h1111_2222);

    // Both masters request continuously against a zero-wait slave.
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("alt_grant", 64'(grant), 64'(exp_g));
      chk("alt_ack",   64'(m_ack), 64'(exp_g));
      step();
      req = ~exp_g; #2;
      chk("alt_dead_grant", 64'(grant), 64'(exp_g));
      chk("alt_dead_ack",   64'(m_ack), 64'h0);
      step();
      req = 2'b11; #2;
    end
    req = 2'b00; stb = 2'b00; s_ack = 1'b0;
    step(); #2;
    chk("idle_grant", 64'(grant), 64'h0);

    // Terminations with no owner are dropped.
    s_ack = 1'b1; s_err = 1'b1; #1;
    chk("idle_ack", 64'(m_ack), 64'h0);
    chk("idle_err", 64'(m_err), 64'h0);
    chk("idle_cyc", 64'(s_cyc), 64'h0);
    step();
    s_ack = 1'b0; s_err = 1'b0;

    // Slave error routed to the LSU only.
    req = 2'b10; stb = 2'b10; we = 2'b00;
    step();
    s_err = 1'b1; #2;
    chk("lsu_err", 64'(m_err), 64'h2);
    step();
    req = 2'b00; stb = 2'b00; s_err = 1'b0;
    step();

    // Prefetch against a slave that never answers.
    req = 2'b01; stb = 2'b01;
    step();
`ifdef RV32IM_ARB_TIMEOUT_EN
    for (int k = 1; k <= int'(TMO); k++) begin
      #2;
      chk("tmo_err", 64'(m_err), (k == int'(TMO)) ? 64'h1 : 64'h0);
      chk("tmo_grant", 64'(grant), 64'h1);
      step();
    end
    req = 2'b00; stb = 2'b00; #2;
    chk("tmo_after_grant", 64'(grant), 64'h0);
    chk("tmo_after_cyc",   64'(s_cyc), 64'h0);
`else
    for (int k = 0; k < 120; k++) step();
    #2;
    chk("stall_grant", 64'(grant), 64'h1);
    chk("stall_err",   64'(m_err), 64'h0);
    step();
    req = 2'b00; stb = 2'b00;
    step();
`endif

    // Asynchronous reset in the middle of an LSU cycle.
    step();
    req = 2'b10; stb = 2'b10;
    step();
    s_ack = 1'b1; #2;
    chk("pre_rst_ack", 64'(m_ack), 64'h2);
    reset_i = 1'b1; #1;
    chk("arst_grant", 64'(grant), 64'h0);
    chk("arst_cyc",   64'(s_cyc), 64'h0);
    chk("arst_stb",   64'(s_stb), 64'h0);
    chk("arst_ack",   64'(m_ack), 64'h0);
    chk("arst_adr",   64'(s_adr), 64'h0);
    step();
    reset_i = 1'b0; req = 2'b00; stb = 2'b00; s_ack = 1'b0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32im_bus_arbiter.md
# rv32im_bus_arbiter

Two-master Wishbone arbiter sharing the single instruction/data memory port of the non-pipelined rv32im core between the instruction prefetch unit (master 0) and the load/store unit (master 1). Owns the req/grant handshake each master uses, muxes the granted master's cycle onto the slave bus, and routes ack/err back to the owner only. Sits between the core masters and the memory/peripheral interconnect.

## Interface
- XLEN, 32, data width and byte address space width
- TIMEOUT_CYCLES, 255, slave wait limit in cycles; used only with RV32IM_ARB_TIMEOUT_EN
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous, active-high reset
- req_i  input  2  bus requests; bit0 prefetch, bit1 load/store
- grant_o  output  2  one-hot ownership; at most one bit set
- m_adr_i  input  2*(XLEN-2)  word addresses; master n at [n*(XLEN-2) +: XLEN-2]
- m_stb_i  input  2  per-master strobes
- m_we_i  input  2  per-master write enables; prefetch ties bit0 low
- m_sel_i  input  8  per-master byte selects, 4 bits each
- m_dat_i  input  2*XLEN  per-master write data
- m_dat_o  output  XLEN  read data, broadcast to both masters
- m_ack_o  output  2  ack routed to owner
- m_err_o  output  2  err routed to owner (includes timeout err)
- s_adr_o  output  XLEN-2  slave word address
- s_dat_o  output  XLEN  slave write data
- s_we_o, s_cyc_o, s_stb_o  output  1 each  slave controls
- s_sel_o  output  4  slave byte selects
- s_dat_i  input  XLEN  slave read data
- s_ack_i, s_err_i  input  1 each  slave termination

## Operation
- States: IDLE (no owner), OWN0, OWN1. Registered owner; grant_o decoded from state.
- IDLE: sample req_i at edge; single request → grant it; both → round-robin, the master not served last wins. After reset, last-served = master 1, so prefetch wins the first tie.
- OWNn: held while req_i[n] high. When req_i[n] sampled low, transition at that edge: directly to the other owner if its req is high, else IDLE. Update last-served to n.
- s_cyc_o = state != IDLE; s_stb_o = s_cyc_o & req_i[owner] & m_stb_i[owner]. s_adr_o/s_dat_o/s_we_o/s_sel_o mux from owner; zero in IDLE.
- m_ack_o[owner] = s_ack_i & s_stb_o; m_err_o[owner] = s_err_i & s_stb_o; non-owner bits always 0. Ack/err with no owner ignored.
- m_dat_o = s_dat_i combinationally.
- Masters drop req_i on the edge that samples ack/err; arbiter never drops grant mid-cycle except on timeout.

## Timing
- Reset (async assert, sync release): state IDLE, grant_o=0, s_cyc_o=s_stb_o=0, all mux outputs 0, m_ack_o=m_err_o=0, timeout counter 0.
- Grant latency: req_i high at edge N → grant_o and s_cyc_o high after edge N.
- Release: one cycle with grant high and req low after ack; next owner granted on the following edge → minimum 1 dead cycle between back-to-back transactions, 3 cycles req-to-ack with a zero-wait slave.
- Simultaneous req drop of owner and rise of other: other granted at same edge.
- Reset mid-cycle: bus outputs drop immediately (asynchronous); any pending ack discarded.

## Configuration
- RV32IM_ARB_TIMEOUT_EN defined: counter increments each cycle s_stb_o high without s_ack_i/s_err_i, clears on termination or owner change. Reaching TIMEOUT_CYCLES: m_err_o[owner] pulses one cycle, state → IDLE at that edge, s_cyc_o/s_stb_o low the next cycle, counter cleared.
- Undefined: no counter; slave may stall indefinitely; TIMEOUT_CYCLES ignored.

## Structure
- Shared package/header rv32im_bus_pkg: owner state encodings (ARB_IDLE, ARB_OWN0, ARB_OWN1), master indices (MASTER_PREFETCH=0, MASTER_LSU=1), sel width constant.
- One sub-module: rv32im_arb_timeout (counter, clear, limit compare), instantiated only under RV32IM_ARB_TIMEOUT_EN.

## Test plan
- Reset released, req_i=2'b11 → grant_o=2'b01 after one edge; s_adr_o = prefetch address.
- Prefetch read 0x0000_0040, slave acks with 0x0010_0093 → m_ack_o=2'b01 one cycle, m_dat_o=0x0010_0093, m_ack_o[1]=0.
- Both requesting continuously → grants alternate 01,10,01 with one dead cycle each handoff.
- LSU write m_sel=4'b0011, m_we=1, data 0xDEAD_BEEF → s_sel_o=0011, s_we_o=1, s_dat_o=0xDEAD_BEEF during OWN1 only.
- s_ack_i pulsed in IDLE → m_ack_o stays 2'b00.
- RV32IM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks → m_err_o[owner] pulses on 8th wait cycle, grant_o=0 next cycle; without macro, grant held 100+ cycles.
